data_memory_arbiter: RTL

- Shares the single byte-addressed data memory between two requesters: port 0 (core load/store unit) and port 1 (loader/debug port).
- Sits between the requesters and data_memory_controller. Drives its addr, data_in, mem_read and write_mode, and captures its data_out.
- Sequences each access as a two-cycle transaction, with round-robin arbitration and alignment and range checks.

---
 rtl/data_memory_arbiter_pkg.sv | 30 +++
 rtl/dmem_req_checker.sv | 37 +++
 rtl/data_memory_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/data_memory_arbiter_pkg.sv
// Shared state encoding, write-mode constants and access-size helper for the
// data memory arbiter and its request checker.
package data_memory_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_e;

    localparam logic [1:0] WM_NONE = 2'd0;
    localparam logic [1:0] WM_BYTE = 2'd1;
    localparam logic [1:0] WM_HALF = 2'd2;
    localparam logic [1:0] WM_WORD = 2'd3;

    // A read always moves a full word; a write moves the bytes its mode names.
    function automatic logic [2:0] sizeFromMode(input logic rd, input logic [1:0] wmode);
        logic [2:0] size;
        if (rd) begin
            size = 3'd4;
        end else begin
            case (wmode)
                WM_BYTE: size = 3'd1;
                WM_HALF: size = 3'd2;
                default: size = 3'd4;
            endcase
        end
        return size;
    endfunction

endpackage

// File: rtl/dmem_req_checker.sv
// Combinational legality check of one memory request: mode consistency,
// natural alignment and range against the memory size.
module dmem_req_checker
    import data_memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_UNITS  = 16
) (
    input  logic                  rd_i,
    input  logic [1:0]            wmode_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  legal_o
);

    localparam int ADDR1 = ADDR_WIDTH + 1;

    logic [2:0]       accessSize;
    logic [ADDR1-1:0] endAddr;
    logic             modeOk;
    logic             alignOk;
    logic             rangeOk;

    // The end address is one bit wider than the bus so a high address cannot wrap into range.
    always_comb begin
        accessSize = sizeFromMode(rd_i, wmode_i);
        endAddr    = {1'b0, addr_i} + ADDR1'(accessSize);
        modeOk     = rd_i ? (wmode_i == WM_NONE) : (wmode_i != WM_NONE);
        case (accessSize)
            3'd2:    alignOk = ~addr_i[0];
            3'd4:    alignOk = (addr_i[1:0] == 2'b00);
            default: alignOk = 1'b1;
        endcase
        rangeOk = (endAddr <= ADDR1'(NUM_UNITS));
        legal_o = modeOk & alignOk & rangeOk;
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing the byte-addressed data memory between the core
// port (0) and the loader/debug port (1); every access is a two-cycle transaction.
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_UNITS  = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  req0_i,
    input  logic                  req1_i,
    input  logic                  rd0_i,
    input  logic                  rd1_i,
    input  logic [1:0]            wmode0_i,
    input  logic [1:0]            wmode1_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic [DATA_WIDTH-1:0] wdata0_i,
    input  logic [DATA_WIDTH-1:0] wdata1_i,
    output logic                  done0_o,
    output logic                  done1_o,
    output logic                  err0_o,
    output logic                  err1_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_in_o,
    output logic                  mem_read_o,
    output logic [1:0]            mem_write_mode_o,
    input  logic [DATA_WIDTH-1:0] mem_data_out_i,
    output logic                  busy_o
);

    arb_state_e            state_q;
    logic                  lastGrant_q;
    logic                  done0_q, done1_q, err0_q, err1_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [ADDR_WIDTH-1:0] memAddr_q;
    logic [DATA_WIDTH-1:0] memDataIn_q;
    logic                  memRead_q;
    logic [1:0]            memWriteMode_q;
    logic                  busy_q;

    logic                  grantOne;
    logic                  selRd;
    logic [1:0]            selWmode;
    logic [ADDR_WIDTH-1:0] selAddr;
    logic [DATA_WIDTH-1:0] selWdata;
    logic                  selLegal;

    // lastGrant_q also names the owner of the access in flight, since every grant updates it.
    always_comb begin
        grantOne = req1_i;
        if (req0_i && req1_i) begin
            grantOne = ~lastGrant_q;
        end
        selRd    = grantOne ? rd1_i    : rd0_i;
        selWmode = grantOne ? wmode1_i : wmode0_i;
        selAddr  = grantOne ? addr1_i  : addr0_i;
        selWdata = grantOne ? wdata1_i : wdata0_i;
    end

    dmem_req_checker #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_UNITS  (NUM_UNITS)
    ) u_checker (
        .rd_i    (selRd),
        .wmode_i (selWmode),
        .addr_i  (selAddr),
        .legal_o (selLegal)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q        <= IDLE;
            lastGrant_q    <= 1'b1;
            done0_q        <= 1'b0;
            done1_q        <= 1'b0;
            err0_q         <= 1'b0;
            err1_q         <= 1'b0;
            rdata_q        <= '0;
            memAddr_q      <= '0;
            memDataIn_q    <= '0;
            memRead_q      <= 1'b0;
            memWriteMode_q <= WM_NONE;
            busy_q         <= 1'b0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0_i || req1_i) begin
                        lastGrant_q <= grantOne;
                        if (selLegal) begin
                            memAddr_q      <= selAddr;
                            memDataIn_q    <= selWdata;
                            memRead_q      <= selRd;
                            memWriteMode_q <= selWmode;
                            busy_q         <= 1'b1;
                            state_q        <= ACCESS;
                        end else begin
                            done0_q <= ~grantOne;
                            done1_q <= grantOne;
                            err0_q  <= ~grantOne;
                            err1_q  <= grantOne;
                        end
                    end
                end
                ACCESS: begin
                    if (memRead_q) begin
                        rdata_q <= mem_data_out_i;
                    end
                    done0_q        <= ~lastGrant_q;
                    done1_q        <= lastGrant_q;
                    memRead_q      <= 1'b0;
                    memWriteMode_q <= WM_NONE;
                    busy_q         <= 1'b0;
                    state_q        <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done0_o          = done0_q;
    assign done1_o          = done1_q;
    assign err0_o           = err0_q;
    assign err1_o           = err1_q;
    assign rdata_o          = rdata_q;
    assign mem_addr_o       = memAddr_q;
    assign mem_data_in_o    = memDataIn_q;
    assign mem_read_o       = memRead_q;
    assign mem_write_mode_o = memWriteMode_q;
    assign busy_o           = busy_q;

endmodule
